instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage that feeds the IF/ID pipeline register. It owns the program counter, issues one address per cycle to a synchronous instruction memory (1-cycle read latency), and presents the returned 20-bit instruction, its 4-bit opcode, its PC and a valid flag to IF/ID. It supports a downstream stall with a one-entry hold buffer, branch redirection with wrong-path squash, and a HALT opcode that freezes fetch.

## Interface
- PC_WIDTH, 8, program counter / instruction memory address width
- RESET_PC, 0, first fetch address after reset
- HALT_OPCODE, 4'hF, opcode that stops fetch
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  downstream not accepting this cycle; output must hold
- branch_taken  in  1  redirect request from a later stage
- branch_target  in  PC_WIDTH  redirect address
- imem_addr  out  PC_WIDTH  read address, equal to pc register
- imem_rdata  in  20  memory data for the address presented the previous cycle
- instruction  out  20  fetched instruction; 20'b0 when valid=0
- opcode  out  4  instruction[19:16]; 4'b0 when valid=0
- pc_out  out  PC_WIDTH  address of instruction on output
- valid  out  1  instruction/opcode/pc_out meaningful
- halted  out  1  fetch frozen by HALT

## Operation
- Registers: pc, last_addr (imem_addr of previous cycle), state, squash, hold_valid, hold_instr, hold_pc.
- States: BOOT, RUN, HALTED. Reset -> BOOT, pc=RESET_PC, squash=0, hold_valid=0.
- BOOT: valid=0; pc <= pc+1 (stall ignored, nothing to hold); -> RUN.
- RUN output source: hold buffer if hold_valid, else imem_rdata with pc_out=last_addr. valid=1 unless squash=1 or branch_taken=1 this cycle.
- RUN, stall=1, branch_taken=0: pc holds; if output valid and hold_valid=0, capture instruction and pc into hold buffer. Output stays stable until stall drops.
- RUN, stall=0, branch_taken=0: output accepted; pc <= pc+1 (wraps mod 2^PC_WIDTH); hold_valid <= 0. Next cycle the memory returns mem[old pc] with pc_out = old pc, so no instruction is skipped or duplicated after a stall.
- branch_taken=1 (any state except reset; beats stall and HALT): pc <= branch_target, hold_valid <= 0, squash <= 1, valid=0 this cycle; state -> RUN (also exits BOOT and HALTED).
- squash=1: valid=0 (in-flight wrong-path data); squash clears next cycle.
- HALT: valid output with opcode=HALT_OPCODE accepted (stall=0, branch_taken=0) -> HALTED. HALTED: pc frozen, valid=0, halted=1; exits only via reset or branch_taken.
- Simultaneous stall and HALT on output: no transition until accepted.

## Timing
- Reset values (cycle after reset high): imem_addr=RESET_PC, valid=0, instruction=0, opcode=0, pc_out=0, halted=0.
- First valid instruction: second cycle after reset release, pc_out=RESET_PC.
- Fetch-to-output latency 1 cycle; throughput 1 instruction/cycle without stall.
- Redirect penalty: valid=0 in redirect cycle and the following cycle; target instruction valid two cycles after branch_taken.
- Stall: outputs identical in every stall cycle; released instruction presented in first stall=0 cycle.
- Reset mid-operation overrides everything, including branch_taken, and discards hold buffer.

## Test plan
- Reset release with mem[i]=i+0x10000: valid at cycle 2 with pc_out=0, instruction=0x10000, then pc_out=1,2,3 consecutively.
- Stall 3 cycles while pc_out=5 shown: instruction/pc_out stay at entry 5 for all stall cycles; after release sequence continues 5,6,7 with no gap or repeat.
- branch_taken with target 0x40 while pc_out=8: valid=0 two cycles, then pc_out=0x40, 0x41.
- branch_taken and stall together: redirect wins, hold cleared, target 0x20 valid two cycles later.
- HALT (0xF0000) at address 3: accepted, then valid=0, halted=1, imem_addr frozen; branch_taken to 0 resumes fetch from 0.
- PC wrap with PC_WIDTH=8 from 0xFE: pc_out 0xFE, 0xFF, 0x00; reset asserted mid-stream returns to reset values next cycle.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and drives a 1-cycle-latency instruction memory, presenting instr/opcode/pc/valid to IF/ID.
// Latency 1 cycle fetch-to-output; stall holds the output via a one-entry buffer, branch squashes two cycles, HALT freezes fetch.
module instruction_fetch #(
    parameter int                    PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [19:0]         imem_rdata,
    output logic [19:0]         instruction,
    output logic [3:0]          opcode,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                valid,
    output logic                halted
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                squash_q, squash_d;
    logic                hold_valid_q, hold_valid_d;
    logic [19:0]         hold_instr_q, hold_instr_d;
    logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;

    logic [19:0]         src_instr;
    logic [PC_WIDTH-1:0] src_pc;
    logic                out_vld;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        last_addr_d  = pc_q;
        squash_d     = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        // The hold buffer, once loaded, shadows the memory so a stalled output never changes.
        src_instr = hold_valid_q ? hold_instr_q : imem_rdata;
        src_pc    = hold_valid_q ? hold_pc_q    : last_addr_q;
        out_vld   = (state_q == ST_RUN) && !squash_q && !branch_taken;

        if (branch_taken) begin
            pc_d         = branch_target;
            hold_valid_d = 1'b0;
            squash_d     = 1'b1;
            state_d      = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stall) begin
                        if (out_vld && !hold_valid_q) begin
                            hold_valid_d = 1'b1;
                            hold_instr_d = src_instr;
                            hold_pc_d    = src_pc;
                        end
                    end else begin
                        pc_d         = pc_q + 1'b1;
                        hold_valid_d = 1'b0;
                        if (out_vld && (src_instr[19:16] == HALT_OPCODE)) begin
                            state_d = ST_HALTED;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        valid       = out_vld;
        instruction = out_vld ? src_instr : 20'b0;
        opcode      = instruction[19:16];
        pc_out      = out_vld ? src_pc : '0;
        halted      = (state_q == ST_HALTED);
        imem_addr   = pc_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            last_addr_q  <= RESET_PC;
            squash_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= 20'b0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            last_addr_q  <= last_addr_d;
            squash_q     <= squash_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for the main stream plus hand sequences for reset and HALT.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [19:0] imem_rdata;
    logic [19:0] instruction;
    logic [3:0]  opcode;
    logic [7:0]  pc_out;
    logic        valid;
    logic        halted;

    logic [19:0] mem [256];

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       s;
        logic       b;
        logic [7:0] tgt;
        logic       v;
        logic [7:0] pc;
        logic [7:0] addr;
    } vec_t;

    vec_t tbl [26];

    instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .opcode        (opcode),
        .pc_out        (pc_out),
        .valid         (valid),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_rdata <= mem[imem_addr];

    function automatic vec_t mk(logic s, logic b, logic [7:0] tgt, logic v, logic [7:0] pc, logic [7:0] addr);
        vec_t r;
        r.s = s; r.b = b; r.tgt = tgt; r.v = v; r.pc = pc; r.addr = addr;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] pc,
                              input logic [19:0] ins, input logic h, input logic [7:0] addr);
        logic [19:0] e_ins;
        logic [7:0]  e_pc;
        e_ins = v ? ins : 20'b0;
        e_pc  = v ? pc : 8'h00;
        cmp({tag, "/valid"},  32'(valid),       32'(v));
        cmp({tag, "/instr"},  32'(instruction), 32'(e_ins));
        cmp({tag, "/opcode"}, 32'(opcode),      32'(e_ins[19:16]));
        cmp({tag, "/pc_out"}, 32'(pc_out),      32'(e_pc));
        cmp({tag, "/halted"}, 32'(halted),      32'(h));
        cmp({tag, "/addr"},   32'(imem_addr),   32'(addr));
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [7:0] tgt);
        @(negedge clock);
        reset = r; stall = s; branch_taken = b; branch_target = tgt;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 20'h10000 + 20'(i);
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;

        tbl[0]  = mk(0, 0, 8'h00, 0, 8'h00, 8'h00);
        tbl[1]  = mk(0, 0, 8'h00, 1, 8'h00, 8'h01);
        tbl[2]  = mk(0, 0, 8'h00, 1, 8'h01, 8'h02);
        tbl[3]  = mk(0, 0, 8'h00, 1, 8'h02, 8'h03);
        tbl[4]  = mk(0, 0, 8'h00, 1, 8'h03, 8'h04);
        tbl[5]  = mk(0, 0, 8'h00, 1, 8'h04, 8'h05);
        tbl[6]  = mk(1, 0, 8'h00, 1, 8'h05, 8'h06);
        tbl[7]  = mk(1, 0, 8'h00, 1, 8'h05, 8'h06);
        tbl[8]  = mk(1, 0, 8'h00, 1, 8'h05, 8'h06);
        tbl[9]  = mk(0, 0, 8'h00, 1, 8'h05, 8'h06);
        tbl[10] = mk(0, 0, 8'h00, 1, 8'h06, 8'h07);
        tbl[11] = mk(0, 0, 8'h00, 1, 8'h07, 8'h08);
        tbl[12] = mk(0, 1, 8'h40, 0, 8'h08, 8'h09);
        tbl[13] = mk(0, 0, 8'h00, 0, 8'h00, 8'h40);
        tbl[14] = mk(0, 0, 8'h00, 1, 8'h40, 8'h41);
        tbl[15] = mk(0, 0, 8'h00, 1, 8'h41, 8'h42);
        tbl[16] = mk(1, 0, 8'h00, 1, 8'h42, 8'h43);
        tbl[17] = mk(1, 1, 8'h20, 0, 8'h42, 8'h43);
        tbl[18] = mk(0, 0, 8'h00, 0, 8'h00, 8'h20);
        tbl[19] = mk(0, 0, 8'h00, 1, 8'h20, 8'h21);
        tbl[20] = mk(0, 1, 8'hFE, 0, 8'h21, 8'h22);
        tbl[21] = mk(0, 0, 8'h00, 0, 8'h00, 8'hFE);
        tbl[22] = mk(0, 0, 8'h00, 1, 8'hFE, 8'hFF);
        tbl[23] = mk(0, 0, 8'h00, 1, 8'hFF, 8'h00);
        tbl[24] = mk(0, 0, 8'h00, 1, 8'h00, 8'h01);
        tbl[25] = mk(1, 0, 8'h00, 1, 8'h01, 8'h02);

        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        expect_out("reset", 0, 8'h00, 20'h0, 0, 8'h00);

        for (int i = 0; i < 26; i++) begin
            step(0, tbl[i].s, tbl[i].b, tbl[i].tgt);
            expect_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc,
                       20'h10000 + 20'(tbl[i].pc), 0, tbl[i].addr);
        end

        // Reset beats a simultaneous branch and discards the held entry 0x01.
        step(1, 1, 1, 8'h40);
        step(1, 1, 1, 8'h40);
        expect_out("mid_reset", 0, 8'h00, 20'h0, 0, 8'h00);

        mem[3] = 20'hF0000;
        step(0, 0, 0, 8'h00);
        expect_out("h_boot", 0, 8'h00, 20'h0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        expect_out("h_pc0", 1, 8'h00, 20'h10000, 0, 8'h01);
        step(0, 0, 0, 8'h00);
        expect_out("h_pc1", 1, 8'h01, 20'h10001, 0, 8'h02);
        step(0, 0, 0, 8'h00);
        expect_out("h_pc2", 1, 8'h02, 20'h10002, 0, 8'h03);
        step(0, 1, 0, 8'h00);
        expect_out("h_stall", 1, 8'h03, 20'hF0000, 0, 8'h04);
        step(0, 0, 0, 8'h00);
        expect_out("h_accept", 1, 8'h03, 20'hF0000, 0, 8'h04);
        step(0, 0, 0, 8'h00);
        expect_out("halted0", 0, 8'h00, 20'h0, 1, 8'h05);
        step(0, 0, 0, 8'h00);
        expect_out("halted1", 0, 8'h00, 20'h0, 1, 8'h05);
        step(0, 1, 0, 8'h00);
        expect_out("halted2", 0, 8'h00, 20'h0, 1, 8'h05);
        step(0, 0, 1, 8'h00);
        expect_out("h_branch", 0, 8'h00, 20'h0, 1, 8'h05);
        step(0, 0, 0, 8'h00);
        expect_out("h_squash", 0, 8'h00, 20'h0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        expect_out("h_resume0", 1, 8'h00, 20'h10000, 0, 8'h01);
        step(0, 0, 0, 8'h00);
        expect_out("h_resume1", 1, 8'h01, 20'h10001, 0, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
